// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared types and helpers for the buffered RV decode stage.
// Micro-op layout is fixed at 64-bit immediates; narrower datapaths truncate.
package decode_queue_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [6:0] OPC_ALUI   = 7'b0010011;
    localparam logic [6:0] OPC_ALU    = 7'b0110011;
    localparam logic [6:0] OPC_ALUIW  = 7'b0011011;
    localparam logic [6:0] OPC_ALUW   = 7'b0111011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LD     = 7'b0000011;
    localparam logic [6:0] OPC_SD     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [3:0] {
        ALUI, ALU, ALUIW, ALUW, LUI, AUIPC,
        JAL, JALR, LD, SD, BZ, BNZ
    } decode_op_t;

    typedef enum logic [4:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        MULT, DIV, DIVU, REM, REMU, EQL, CPYB, NOTALU
    } alufunc_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_t;

    typedef struct packed {
        decode_op_t          op;
        alufunc_t            alufunc;
        logic                regwrite;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [MAX_XLEN-1:0] imm;
        logic                illegal;
    } uop_t;

    function automatic alufunc_t base_fn(input logic [2:0] f3,
                                         input logic alt);
        alufunc_t fn;
        case (f3)
            3'b000:  fn = alt ? SUB : ADD;
            3'b001:  fn = SLL;
            3'b010:  fn = SLT;
            3'b011:  fn = SLTU;
            3'b100:  fn = XOR;
            3'b101:  fn = alt ? SRA : SRL;
            3'b110:  fn = OR;
            default: fn = AND;
        endcase
        return fn;
    endfunction

    function automatic alufunc_t m_fn(input logic [2:0] f3);
        alufunc_t fn;
        case (f3)
            3'b000:  fn = MULT;
            3'b100:  fn = DIV;
            3'b101:  fn = DIVU;
            3'b110:  fn = REM;
            3'b111:  fn = REMU;
            default: fn = NOTALU;
        endcase
        return fn;
    endfunction

    function automatic logic [MAX_XLEN-1:0] gen_imm(input logic [31:0] i,
                                                   input imm_type_t t);
        logic [MAX_XLEN-1:0] imm;
        case (t)
            IMM_I:   imm = {{52{i[31]}}, i[31:20]};
            IMM_S:   imm = {{52{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm = {{32{i[31]}}, i[31:12], 12'b0};
            IMM_J:   imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_queue_core.sv
// rv_decode_core: combinational instruction -> micro-op decoder with strict
// encoding checks; illegal encodings collapse to a harmless ALUI/NOTALU op.
module rv_decode_core
    import decode_queue_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] instr,
    output uop_t        uop
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       sh_hi64;
    logic       sh_hi32;
    logic       m_bad;
    logic       w_f3_ok;
    logic       alt_ok;

    decode_op_t op;
    alufunc_t   fn;
    imm_type_t  it;
    logic       we;
    logic       bad;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign sh_hi64 = |{instr[31], instr[29:26]};
    assign sh_hi32 = |{instr[31], instr[29:25]};
    assign m_bad   = funct3 inside {3'b001, 3'b010, 3'b011};
    assign w_f3_ok = funct3 inside {3'b000, 3'b001, 3'b101};
    assign alt_ok  = funct3 inside {3'b000, 3'b101};

    always_comb begin
        op  = ALUI;
        fn  = ADD;
        it  = IMM_NONE;
        we  = 1'b1;
        bad = 1'b0;
        case (opcode)
            OPC_ALUI: begin
                it = IMM_I;
                fn = base_fn(funct3, instr[30] && funct3 == 3'b101);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    bad = (XLEN == 32) ? sh_hi32 : sh_hi64;
                end
            end
            OPC_ALU: begin
                op = ALU;
                case (funct7)
                    F7_BASE: fn = base_fn(funct3, 1'b0);
                    F7_ALT: begin
                        fn  = base_fn(funct3, 1'b1);
                        bad = !alt_ok;
                    end
                    F7_MUL: begin
                        fn  = m_fn(funct3);
                        bad = !ENABLE_M || m_bad;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_ALUIW: begin
                op = ALUIW;
                it = IMM_I;
                fn = base_fn(funct3, instr[30] && funct3 == 3'b101);
                bad = (XLEN == 32) || !w_f3_ok ||
                      (funct3 != 3'b000 && sh_hi32);
            end
            OPC_ALUW: begin
                op = ALUW;
                case (funct7)
                    F7_BASE: begin
                        fn  = base_fn(funct3, 1'b0);
                        bad = !w_f3_ok;
                    end
                    F7_ALT: begin
                        fn  = base_fn(funct3, 1'b1);
                        bad = !alt_ok;
                    end
                    F7_MUL: begin
                        fn  = m_fn(funct3);
                        bad = !ENABLE_M || m_bad;
                    end
                    default: bad = 1'b1;
                endcase
                if (XLEN == 32) bad = 1'b1;
            end
            OPC_LUI: begin
                op = LUI;
                fn = CPYB;
                it = IMM_U;
            end
            OPC_AUIPC: begin
                op = AUIPC;
                it = IMM_U;
            end
            OPC_JAL: begin
                op = JAL;
                it = IMM_J;
            end
            OPC_JALR: begin
                op  = JALR;
                it  = IMM_I;
                bad = funct3 != 3'b000;
            end
            OPC_LD: begin
                op = LD;
                it = IMM_I;
            end
            OPC_SD: begin
                op = SD;
                it = IMM_S;
                we = 1'b0;
            end
            OPC_BRANCH: begin
                op  = funct3[0] ? BNZ : BZ;
                it  = IMM_B;
                we  = 1'b0;
                bad = funct3[2:1] == 2'b01;
                case (funct3[2:1])
                    2'b10:   fn = SLT;
                    2'b11:   fn = SLTU;
                    default: fn = EQL;
                endcase
            end
            default: bad = 1'b1;
        endcase
        // Keep illegal ops in program order but make them inert downstream.
        if (bad) begin
            op = ALUI;
            fn = NOTALU;
            it = IMM_NONE;
            we = 1'b0;
        end
    end

    always_comb begin
        uop          = '0;
        uop.op       = op;
        uop.alufunc  = fn;
        uop.regwrite = we;
        uop.rd       = instr[11:7];
        uop.rs1      = instr[19:15];
        uop.rs2      = instr[24:20];
        uop.imm      = gen_imm(instr, it);
        uop.illegal  = bad;
    end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: decodes fetched instructions and buffers the micro-ops in a
// DEPTH-entry FIFO between fetch and issue, with flush.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int DEPTH    = 4,
    parameter bit ENABLE_M = 1'b1,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output decode_op_t      out_op,
    output alufunc_t        out_alufunc,
    output logic            out_regwrite,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic [CW-1:0]   count
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    uop_t            dec_uop;
    uop_t            mem_q [DEPTH];
    uop_t            mem_d [DEPTH];
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [XLEN-1:0] pc_d  [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;

    rv_decode_core #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_core (
        .instr (in_instr),
        .uop   (dec_uop)
    );

    assign out_valid = count_q != '0;
    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready  = (count_q < CW'(DEPTH)) || (out_valid && out_ready);
    assign count     = count_q;

    always_comb begin
        push    = in_valid && in_ready && !flush;
        pop     = out_valid && out_ready && !flush;
        mem_d   = mem_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = dec_uop;
                pc_d[tail_q]  = in_pc;
                tail_d        = tail_q + PTR_ONE;
            end
            if (pop) head_d = head_q + PTR_ONE;
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
            pc_q    <= pc_d;
        end
    end

    assign out_pc       = pc_q[head_q];
    assign out_op       = mem_q[head_q].op;
    assign out_alufunc  = mem_q[head_q].alufunc;
    assign out_regwrite = mem_q[head_q].regwrite;
    assign out_rd       = mem_q[head_q].rd;
    assign out_rs1      = mem_q[head_q].rs1;
    assign out_rs2      = mem_q[head_q].rs2;
    assign out_imm      = mem_q[head_q].imm[XLEN-1:0];
    assign out_illegal  = mem_q[head_q].illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed checks of decode and FIFO behaviour on a 64-bit
// M-enabled queue and a 32-bit queue without M, driven in lockstep.
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready, out_valid, out_regwrite, out_illegal;
    logic [63:0] out_pc, out_imm;
    decode_op_t  out_op;
    alufunc_t    out_alufunc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  count;

    logic        in_ready32, out_valid32, out_regwrite32, out_illegal32;
    logic [31:0] out_pc32, out_imm32;
    decode_op_t  out_op32;
    alufunc_t    out_alufunc32;
    logic [4:0]  out_rd32, out_rs132, out_rs232;
    logic [2:0]  count32;

    int n_chk  = 0;
    int n_pass = 0;

    decode_queue #(.XLEN(64), .DEPTH(4), .ENABLE_M(1'b1)) u_dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op(out_op), .out_alufunc(out_alufunc),
        .out_regwrite(out_regwrite), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .out_illegal(out_illegal),
        .count(count)
    );

    decode_queue #(.XLEN(32), .DEPTH(4), .ENABLE_M(1'b0)) u_dut32 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_pc(out_pc32), .out_op(out_op32), .out_alufunc(out_alufunc32),
        .out_regwrite(out_regwrite32), .out_rd(out_rd32), .out_rs1(out_rs132),
        .out_rs2(out_rs232), .out_imm(out_imm32), .out_illegal(out_illegal32),
        .count(count32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_valid32", out_valid32, 0);
        resetn = 1'b1;
        @(negedge clk);

        // addi x1,x0,5
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h100;
        #1 chk("addi_lat0", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("addi_valid", out_valid, 1);
        chk("addi_op", out_op, ALUI);
        chk("addi_fn", out_alufunc, ADD);
        chk("addi_rd", out_rd, 1);
        chk("addi_rs1", out_rs1, 0);
        chk("addi_imm", out_imm, 5);
        chk("addi_ill", out_illegal, 0);
        chk("addi_we", out_regwrite, 1);
        chk("addi_pc", out_pc, 64'h100);
        chk("addi_cnt", count, 1);
        pop_one();
        chk("addi_empty", out_valid, 0);

        // beq x0,x0,-4
        push_one(32'hFE000EE3, 64'h104);
        chk("beq_op", out_op, BZ);
        chk("beq_fn", out_alufunc, EQL);
        chk("beq_we", out_regwrite, 0);
        chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_imm32", out_imm32, 32'hFFFF_FFFC);
        pop_one();

        // mul x3,x1,x2
        push_one(32'h022081B3, 64'h108);
        chk("mul_fn", out_alufunc, MULT);
        chk("mul_rd", out_rd, 3);
        chk("mul_rs1", out_rs1, 1);
        chk("mul_rs2", out_rs2, 2);
        chk("mul_ill", out_illegal, 0);
        chk("mul_ill32", out_illegal32, 1);
        chk("mul_we32", out_regwrite32, 0);
        chk("mul_fn32", out_alufunc32, NOTALU);
        chk("mul_op32", out_op32, ALUI);
        pop_one();

        // zero word then lui x5,0x12345, kept in order
        push_one(32'h00000000, 64'h10C);
        push_one(32'h123452B7, 64'h110);
        chk("zero_cnt", count, 2);
        chk("zero_ill", out_illegal, 1);
        chk("zero_we", out_regwrite, 0);
        chk("zero_fn", out_alufunc, NOTALU);
        chk("zero_imm", out_imm, 0);
        pop_one();
        chk("lui_op", out_op, LUI);
        chk("lui_fn", out_alufunc, CPYB);
        chk("lui_imm", out_imm, 64'h12345000);
        chk("lui_rd", out_rd, 5);
        chk("lui_imm32", out_imm32, 32'h12345000);
        chk("lui_pc", out_pc, 64'h110);
        pop_one();

        // addw x1,x2,x3
        push_one(32'h003100BB, 64'h114);
        chk("addw_op", out_op, ALUW);
        chk("addw_ill", out_illegal, 0);
        chk("addw_ill32", out_illegal32, 1);
        pop_one();

        // srai x1,x1,33: legal only with a 6-bit shamt
        push_one(32'h4210D093, 64'h118);
        chk("srai_fn", out_alufunc, SRA);
        chk("srai_ill", out_illegal, 0);
        chk("srai_imm", out_imm, 64'h421);
        chk("srai_ill32", out_illegal32, 1);
        pop_one();

        // fill, hold the 5th offer, then pop+push while full
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h00000093 | (32'(i) << 20);
            in_pc    = 64'h200 + 64'(4 * i);
            @(posedge clk);
            @(negedge clk);
        end
        in_instr = 32'h00000093 | (32'd4 << 20);
        in_pc    = 64'h210;
        #1;
        chk("full_ready", in_ready, 0);
        chk("full_cnt", count, 4);
        @(posedge clk);
        @(negedge clk);
        chk("full_hold_cnt", count, 4);
        chk("full_hold_pc", out_pc, 64'h200);
        out_ready = 1'b1;
        #1 chk("full_ready_pop", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_pp_cnt", count, 4);
        for (int i = 1; i < 5; i++) begin
            chk("wrap_pc", out_pc, 64'h200 + 64'(4 * i));
            chk("wrap_imm", out_imm, 64'(i));
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_cnt", count, 0);
        chk("drain_valid", out_valid, 0);

        // flush beats a same-cycle push and pop
        push_one(32'h00100093, 64'h300);
        push_one(32'h00200093, 64'h304);
        push_one(32'h00300093, 64'h308);
        chk("pre_flush_cnt", count, 3);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_instr = 32'h00700093; in_pc = 64'h3FC;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_cnt", count, 0);
        chk("flush_valid", out_valid, 0);
        push_one(32'h00900093, 64'h400);
        chk("post_flush_cnt", count, 1);
        chk("post_flush_pc", out_pc, 64'h400);
        chk("post_flush_imm", out_imm, 9);
        pop_one();

        // asynchronous reset in mid-stream
        push_one(32'h00100093, 64'h500);
        push_one(32'h00200093, 64'h504);
        chk("pre_rst_cnt", count, 2);
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_cnt", count, 0);
        chk("arst_valid32", out_valid32, 0);
        @(negedge clk);
        resetn = 1'b1;
        push_one(32'h123452B7, 64'h600);
        chk("rel_valid", out_valid, 1);
        chk("rel_pc", out_pc, 64'h600);
        chk("rel_cnt", count, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
